// File: rtl/test_pulse_encoder.sv
// Push-button front end for the FSM test interface.
// Long press enters test mode, short presses pick a code.
module test_pulse_encoder #(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_PRESS      = 150000000,
  parameter int IDLE_TIMEOUT    = 100000000,
  parameter int HOLD_CYCLES     = 16,
  parameter int MAX_COUNT       = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       boton_raw,
  output logic       botonTest,
  output logic [3:0] BpulseTest,
  output logic       press_pulse
);

  localparam int DW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LW =
    (LONG_PRESS > 1) ? $clog2(LONG_PRESS) : 1;
  localparam int IW =
    (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam int HW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LP_LAST = LW'(LONG_PRESS - 1);
  localparam logic [IW-1:0] IT_LAST = IW'(IDLE_TIMEOUT - 1);
  localparam logic [HW-1:0] HC_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [3:0]    CODE_MAX = 4'(MAX_COUNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMING,
    S_WAIT_REL,
    S_COUNT,
    S_COMMIT
  } state_t;

  state_t          state;
  logic            raw_n;
  logic            sync1;
  logic            sync2;
  logic            db;
  logic [DW-1:0]   db_cnt;
  logic [LW-1:0]   long_cnt;
  logic [IW-1:0]   idle_cnt;
  logic [HW-1:0]   hold_cnt;

  // pressed reads as 1 regardless of board polarity
  assign raw_n = boton_raw ^ ACTIVE_LOW;

  // two-flop synchronizer on the normalized pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw_n;
      sync2 <= sync1;
    end
  end

  // debounce: flip only after a sustained mismatch, strobe on press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db          <= 1'b0;
      db_cnt      <= '0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      if (sync2 == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db          <= ~db;
        db_cnt      <= '0;
        press_pulse <= ~db;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // mode FSM: arm on long press, count short presses, commit on idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      botonTest  <= 1'b0;
      BpulseTest <= 4'd0;
      long_cnt   <= '0;
      idle_cnt   <= '0;
      hold_cnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          botonTest  <= 1'b0;
          BpulseTest <= 4'd0;
          if (press_pulse) begin
            state    <= S_ARMING;
            long_cnt <= '0;
          end
        end
        S_ARMING: begin
          if (!db) begin
            state <= S_IDLE;
          end else if (long_cnt == LP_LAST) begin
            state     <= S_WAIT_REL;
            botonTest <= 1'b1;
          end else begin
            long_cnt <= long_cnt + 1'b1;
          end
        end
        S_WAIT_REL: begin
          if (!db) begin
            state    <= S_COUNT;
            idle_cnt <= '0;
            long_cnt <= '0;
          end
        end
        S_COUNT: begin
          if (press_pulse) begin
            if (BpulseTest < CODE_MAX) begin
              BpulseTest <= BpulseTest + 4'd1;
            end
            idle_cnt <= '0;
            long_cnt <= '0;
          end else if (db) begin
            if (long_cnt == LP_LAST) begin
              BpulseTest <= 4'd0;
              state      <= S_WAIT_REL;
            end else begin
              long_cnt <= long_cnt + 1'b1;
            end
          end else if (idle_cnt == IT_LAST) begin
            idle_cnt <= '0;
            // a zero code would strand the FSM, so keep waiting
            if (BpulseTest != 4'd0) begin
              state     <= S_COMMIT;
              botonTest <= 1'b0;
              hold_cnt  <= '0;
            end
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        S_COMMIT: begin
          if (hold_cnt == HC_LAST) begin
            BpulseTest <= 4'd0;
            state      <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
